// File: rtl/lemming_pkg.sv
// ============================================================================
// Module   : lemming_pkg
// Purpose  : Shared state encoding and output decode for the lemming walkers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lemming_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } lem_state_t;

  typedef struct packed {
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
  } lem_out_t;

  function automatic lem_out_t decode_outputs(input lem_state_t s);
    lem_out_t o;
    o            = '0;
    o.walk_left  = (s == WALK_L);
    o.walk_right = (s == WALK_R);
    o.aaah       = (s == FALL_L) || (s == FALL_R);
    o.digging    = (s == DIG_L)  || (s == DIG_R);
    return o;
  endfunction

  function automatic logic is_fall(input lem_state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

  function automatic logic is_dig(input lem_state_t s);
    return (s == DIG_L) || (s == DIG_R);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lemming_fsm.sv
// ============================================================================
// Module   : lemming_fsm
// Purpose  : One lemming channel: walk/fall/dig FSM with splat and dig limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lemming_fsm
  import lemming_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20,
  parameter int DIG_MAX      = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  localparam int FALL_W = $clog2(SPLAT_CYCLES + 2);
  localparam int DIG_W  = (DIG_MAX > 0) ? $clog2(DIG_MAX + 1) : 1;
  localparam logic [FALL_W-1:0] FALL_LIMIT = FALL_W'(SPLAT_CYCLES);
  localparam logic [FALL_W-1:0] FALL_SAT   = FALL_W'(SPLAT_CYCLES + 1);
  localparam logic [DIG_W-1:0]  DIG_LIMIT  = DIG_W'(DIG_MAX);

  lem_state_t        state;
  lem_state_t        state_nxt;
  logic [FALL_W-1:0] fall_cnt;
  logic [DIG_W-1:0]  dig_cnt;
  logic              fall_over;
  logic              dig_done;
  lem_out_t          outs;

  // fall_cnt saturates one past the limit, so "greater than" marks a fatal fall
  assign fall_over = (fall_cnt > FALL_LIMIT);
  assign dig_done  = (DIG_MAX > 0) && (dig_cnt == DIG_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      WALK_L: begin
        if (!ground)        state_nxt = FALL_L;
        else if (dig)       state_nxt = DIG_L;
        else if (bump_left) state_nxt = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_nxt = FALL_R;
        else if (dig)        state_nxt = DIG_R;
        else if (bump_right) state_nxt = WALK_L;
      end
      FALL_L: if (ground) state_nxt = fall_over ? SPLAT : WALK_L;
      FALL_R: if (ground) state_nxt = fall_over ? SPLAT : WALK_R;
      DIG_L: begin
        if (!ground)      state_nxt = FALL_L;
        else if (dig_done) state_nxt = WALK_L;
      end
      DIG_R: begin
        if (!ground)      state_nxt = FALL_R;
        else if (dig_done) state_nxt = WALK_R;
      end
      SPLAT:   state_nxt = SPLAT;
      default: state_nxt = WALK_L;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WALK_L;
      fall_cnt <= '0;
      dig_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (!is_fall(state_nxt))
        fall_cnt <= '0;
      else if (!is_fall(state))
        fall_cnt <= FALL_W'(1);
      else if (fall_cnt != FALL_SAT)
        fall_cnt <= fall_cnt + FALL_W'(1);

      if ((DIG_MAX == 0) || !is_dig(state_nxt))
        dig_cnt <= '0;
      else if (!is_dig(state))
        dig_cnt <= DIG_W'(1);
      else
        dig_cnt <= dig_cnt + DIG_W'(1);
    end
  end

  assign outs       = decode_outputs(state);
  assign walk_left  = outs.walk_left;
  assign walk_right = outs.walk_right;
  assign aaah       = outs.aaah;
  assign digging    = outs.digging;
  assign splat      = (state == SPLAT);

endmodule

`default_nettype wire

// File: rtl/lemming_ctrl_array.sv
// ============================================================================
// Module   : lemming_ctrl_array
// Purpose  : NUM_LEM independent lemming walkers plus registered dead count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lemming_ctrl_array
  import lemming_pkg::*;
#(
  parameter int NUM_LEM      = 4,
  parameter int SPLAT_CYCLES = 20,
  parameter int DIG_MAX      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LEM-1:0]           bump_left,
  input  logic [NUM_LEM-1:0]           bump_right,
  input  logic [NUM_LEM-1:0]           ground,
  input  logic [NUM_LEM-1:0]           dig,
  output logic [NUM_LEM-1:0]           walk_left,
  output logic [NUM_LEM-1:0]           walk_right,
  output logic [NUM_LEM-1:0]           aaah,
  output logic [NUM_LEM-1:0]           digging,
  output logic [$clog2(NUM_LEM+1)-1:0] dead_cnt
);

  localparam int CNT_W = $clog2(NUM_LEM + 1);

  logic [NUM_LEM-1:0] splat_vec;
  logic [CNT_W-1:0]   splat_sum;

  generate
    for (genvar i = 0; i < NUM_LEM; i++) begin : g_lem
      lemming_fsm #(
        .SPLAT_CYCLES (SPLAT_CYCLES),
        .DIG_MAX      (DIG_MAX)
      ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .bump_left  (bump_left[i]),
        .bump_right (bump_right[i]),
        .ground     (ground[i]),
        .dig        (dig[i]),
        .walk_left  (walk_left[i]),
        .walk_right (walk_right[i]),
        .aaah       (aaah[i]),
        .digging    (digging[i]),
        .splat      (splat_vec[i])
      );
    end
  endgenerate

  always_comb begin
    splat_sum = '0;
    for (int i = 0; i < NUM_LEM; i++)
      splat_sum = splat_sum + CNT_W'(splat_vec[i]);
  end

  // Counts from the current state register, hence one cycle behind a splat
  always_ff @(posedge clk) begin
    if (reset) dead_cnt <= '0;
    else       dead_cnt <= splat_sum;
  end

endmodule

`default_nettype wire

// File: tb/tb_lemming_ctrl_array.sv
// ============================================================================
// Module   : tb_lemming_ctrl_array
// Purpose  : Scoreboard bench for two lemming arrays (DIG_MAX=0 and DIG_MAX=5).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lemming_ctrl_array;

  localparam int N  = 4;
  localparam int S  = 20;
  localparam int CW = $clog2(N + 1);
  localparam int M_WALK = 0, M_FALL = 1, M_DIG = 2, M_DEAD = 3;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] bump_left, bump_right, ground, dig;
  logic [N-1:0] a_wl, a_wr, a_aaah, a_dig, b_wl, b_wr, b_aaah, b_dig;
  logic [CW-1:0] a_dead, b_dead;

  always #5 clk = ~clk;

  lemming_ctrl_array #(.NUM_LEM(N), .SPLAT_CYCLES(S), .DIG_MAX(0)) dut_a (
    .clk(clk), .reset(reset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(a_wl), .walk_right(a_wr),
    .aaah(a_aaah), .digging(a_dig), .dead_cnt(a_dead));

  lemming_ctrl_array #(.NUM_LEM(N), .SPLAT_CYCLES(S), .DIG_MAX(5)) dut_b (
    .clk(clk), .reset(reset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(b_wl), .walk_right(b_wr),
    .aaah(b_aaah), .digging(b_dig), .dead_cnt(b_dead));

  int total = 0;
  int bad   = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int mode[2][N];
  int dr[2][N];
  int fc[2][N];
  int dc[2][N];
  int dmax[2] = '{0, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one edge for instance k; returns packed expected outputs
  task automatic model_edge(input int k, output logic [31:0] e);
    int dead = 0;
    logic [N-1:0] wl, wr, fa, dg;
    for (int i = 0; i < N; i++) if (mode[k][i] == M_DEAD) dead++;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        mode[k][i] = M_WALK; dr[k][i] = 0; fc[k][i] = 0; dc[k][i] = 0;
      end else begin
        case (mode[k][i])
          M_WALK: begin
            if (!ground[i]) begin mode[k][i] = M_FALL; fc[k][i] = 1; end
            else if (dig[i]) begin mode[k][i] = M_DIG; dc[k][i] = 1; end
            else if (dr[k][i] == 0 ? bump_left[i] : bump_right[i]) dr[k][i] = 1 - dr[k][i];
          end
          M_FALL: begin
            if (ground[i]) begin
              mode[k][i] = (fc[k][i] > S) ? M_DEAD : M_WALK;
              fc[k][i] = 0;
            end else if (fc[k][i] <= S) fc[k][i]++;
          end
          M_DIG: begin
            if (!ground[i]) begin mode[k][i] = M_FALL; fc[k][i] = 1; dc[k][i] = 0; end
            else if (dmax[k] > 0 && dc[k][i] == dmax[k]) begin mode[k][i] = M_WALK; dc[k][i] = 0; end
            else dc[k][i]++;
          end
          default: ;
        endcase
      end
      wl[i] = (mode[k][i] == M_WALK) && (dr[k][i] == 0);
      wr[i] = (mode[k][i] == M_WALK) && (dr[k][i] == 1);
      fa[i] = (mode[k][i] == M_FALL);
      dg[i] = (mode[k][i] == M_DIG);
    end
    e = 32'({wl, wr, fa, dg, CW'(reset ? 0 : dead)});
  endtask

  task automatic step();
    logic [31:0] e;
    model_edge(0, e); qa.push_back(e);
    model_edge(1, e); qb.push_back(e);
    @(posedge clk);
    #1;
    chk("outA", 32'({a_wl, a_wr, a_aaah, a_dig, a_dead}), qa.pop_front());
    chk("outB", 32'({b_wl, b_wr, b_aaah, b_dig, b_dead}), qb.pop_front());
  endtask

  initial begin
    int na, nb;
    reset = 1'b1; ground = '1; dig = '0; bump_left = '0; bump_right = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_walk_left", a_wl, 4'hF);
    chk("rst_dead", a_dead, 0);

    bump_left[0] = 1'b1; step(); bump_left[0] = 1'b0;
    chk("bump_wr", b_wr, 4'b0001);
    chk("bump_wl", a_wl, 4'b1110);

    na = 0;
    ground[1] = 1'b0;
    for (int c = 0; c < S; c++) begin step(); if (a_aaah[1]) na++; end
    ground[1] = 1'b1; step();
    chk("fall20_len", na, S);
    chk("fall20_walk", a_wl[1], 1);

    ground[1] = 1'b0;
    repeat (S + 1) step();
    ground[1] = 1'b1; step();
    chk("splat_outs", {a_wl[1], a_wr[1], a_aaah[1], a_dig[1]}, 0);
    chk("splat_dead_lag", a_dead, 0);
    step();
    chk("splat_dead", a_dead, 1);

    bump_left[2] = 1'b1; step(); bump_left[2] = 1'b0;
    dig[2] = 1'b1; step(); dig[2] = 1'b0;
    na = a_dig[2]; nb = b_dig[2];
    for (int c = 0; c < 7; c++) begin step(); na += a_dig[2]; nb += b_dig[2]; end
    chk("dig0_len", na, 8);
    chk("dig5_len", nb, 5);
    chk("dig5_walk", b_wr[2], 1);
    ground[2] = 1'b0; step();
    chk("dig0_fall", a_aaah[2], 1);
    repeat (2) step();
    ground[2] = 1'b1; step();
    chk("dig0_back", a_wr[2], 1);

    ground[3] = 1'b0; dig[3] = 1'b1; bump_left[3] = 1'b1; step();
    ground[3] = 1'b1; dig[3] = 1'b0; bump_left[3] = 1'b0;
    chk("fall_wins", a_aaah[3], 1);
    step();
    chk("fall_wins_back", a_wl[3], 1);

    ground[0] = 1'b0;
    repeat (S + 2) step();
    ground[0] = 1'b1; step(); step();
    chk("dead2", a_dead, 2);
    ground[3] = 1'b0;
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0; ground = '1;
    chk("reset_wl", a_wl, 4'hF);
    chk("reset_dead", a_dead, 0);
    chk("reset_dead_b", b_dead, 0);

    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 80) == 0);
      for (int i = 0; i < N; i++) begin
        ground[i]     = ($urandom_range(0, 5) != 0);
        dig[i]        = ($urandom_range(0, 9) == 0);
        bump_left[i]  = ($urandom_range(0, 3) == 0);
        bump_right[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lemming_ctrl_array.md
# lemming_ctrl_array

Parametrised array of NUM_LEM independent Lemmings walker controllers with a splat-on-long-fall rule and an optional bounded dig. It extends the team's single-lemming walk/fall/dig FSM with channel count, fall-height threshold, dig timeout and a registered dead-lemming count. It sits between the per-lemming terrain sensor block and the sprite/animation output stage.

## Interface
Parameters:
- NUM_LEM, 4: number of independent lemming channels (≥1).
- SPLAT_CYCLES, 20: maximum survivable fall length in cycles (≥1).
- DIG_MAX, 0: dig duration limit in cycles; 0 means unbounded (dig until ground lost).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- bump_left  in  NUM_LEM  per-channel left obstacle.
- bump_right  in  NUM_LEM  per-channel right obstacle.
- ground  in  NUM_LEM  per-channel ground present.
- dig  in  NUM_LEM  per-channel dig request.
- walk_left  out  NUM_LEM  channel walking left.
- walk_right  out  NUM_LEM  channel walking right.
- aaah  out  NUM_LEM  channel falling.
- digging  out  NUM_LEM  channel digging.
- dead_cnt  out  $clog2(NUM_LEM+1)  number of channels in SPLAT.

## Operation
- Per channel, states: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Moore outputs: WALK_L→walk_left, WALK_R→walk_right, FALL_*→aaah, DIG_*→digging, SPLAT→all four 0.
- WALK_x: ground=0 → FALL_x; else dig=1 → DIG_x; else bump toward current direction (or both bumps) → WALK of opposite direction; else stay. Priority fall > dig > bump; bump away from current direction ignored.
- FALL_x: ground=0 → stay; ground=1 → SPLAT if fall_cnt > SPLAT_CYCLES, else WALK_x (original direction; bumps ignored while falling).
- DIG_x: ground=0 → FALL_x; else if DIG_MAX>0 and dig_cnt = DIG_MAX → WALK_x; else stay. dig input and bumps ignored while digging.
- SPLAT: absorbing until reset.
- fall_cnt: per-channel, width $clog2(SPLAT_CYCLES+2); loaded to 1 on entry to FALL_*, +1 each further FALL cycle, saturates at SPLAT_CYCLES+1; equals count of cycles aaah has been high including current.
- dig_cnt: per-channel, width $clog2(DIG_MAX+1) (min 1); loaded to 1 on entry to DIG_*, +1 per further DIG cycle; unused/held 0 when DIG_MAX=0.
- dead_cnt: registered population count of channels in SPLAT, derived from current state vector.
- Channels fully independent; no shared arbitration.

## Timing
- Reset: every channel WALK_L; walk_left all 1, other outputs 0; counters 0; dead_cnt 0.
- Inputs sampled on rising edge; outputs reflect new state in the same cycle as state change (Moore, one cycle after stimulus).
- Splat boundary: aaah high exactly SPLAT_CYCLES cycles then ground → walk; SPLAT_CYCLES+1 cycles → SPLAT.
- dead_cnt lags the state change into SPLAT by one cycle.
- Reset mid-fall/dig/splat: returns to WALK_L next edge, counters cleared; reset overrides all inputs.
- Simultaneous ground loss + dig + bump in WALK: FALL wins.

## Structure
- Package lemming_pkg: lem_state_t enum (3-bit, values above), output-decode function.
- Sub-module lemming_fsm: one channel (state, fall_cnt, dig_cnt, outputs), instantiated NUM_LEM times via generate; top adds popcount register.

## Test plan
- Reset, ground=all 1, no bumps → walk_left=4'b1111; bump_left[0] one cycle → next cycle walk_right[0]=1, others unchanged.
- Channel 1 ground=0 for 20 cycles then 1 (SPLAT_CYCLES=20) → aaah[1] high 20 cycles, then walk_left[1]=1; repeat with 21 cycles → all outputs[1]=0, dead_cnt=1 one cycle later.
- DIG_MAX=5: dig[2] pulse while walking right, ground held 1 → digging[2] high exactly 5 cycles, then walk_right[2]=1.
- DIG_MAX=0: dig then ground=0 after 8 cycles → digging 8 cycles, then aaah; ground=1 after 3 → walk same direction.
- Same cycle ground=0, dig=1, bump_left=1 on channel 3 walking left → next state FALL_L (aaah[3]=1).
- Two channels splat, then reset mid-fall of another → all WALK_L, dead_cnt=0 after reset cycle.
